csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width (32 or 64).
REQ-002 SHALL have parameter HAS_COUNTERS, default 1, meaning mcycle/minstret are implemented; when 0 the counter addresses are unimplemented.
REQ-003 SHALL have parameter MTVEC_RST, default 0, meaning the mtvec reset value.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port csr_en, input, 1, meaning a Zicsr instruction is valid this cycle.
REQ-007 SHALL have port funct3, input, 3, meaning 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-008 SHALL have port csr_addr, input, 12, meaning the target CSR.
REQ-009 SHALL have port src1, input, XLEN, meaning the rs1 value.
REQ-010 SHALL have port zimm, input, 5, meaning the rs1 field (immediate operand; zero-extended).
REQ-011 SHALL have ports is_ecall, is_mret, inst_retire, pc: inputs of 1, 1, 1 and XLEN bits, meaning trap entry, trap return, instruction retired, and current PC.
REQ-012 SHALL have port csr_rdata, output, XLEN, meaning the old CSR value (combinational).
REQ-013 SHALL have ports trap_npc (output, XLEN) and trap_taken (output, 1), meaning the redirect target and that a redirect is valid (combinational).
REQ-014 SHALL have port csr_illegal, output, 1, meaning a registered one-cycle illegal-access pulse.

Function
REQ-015 Implemented CSRs SHALL be: mstatus 0x300 (MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; other bits read 0), mtvec 0x305, mscratch 0x340, mepc 0x341 (bits[1:0] read 0), mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80 and minstreth 0xB82 (XLEN=32 only), and mvendorid 0xF11 and marchid 0xF12 (read-only, both 0).
REQ-016 Operand SHALL be src1 for funct3[2]=0 and zero-extended zimm for funct3[2]=1.
REQ-017 Write data SHALL be: RW = operand; RS = old|operand; RC = old&~operand.
REQ-018 RS/RC/RSI/RCI with rs1 field (zimm) == 0 SHALL perform no write and SHALL raise no read-only fault.
REQ-019 csr_illegal SHALL pulse in the cycle after csr_en when the address is unimplemented, or when a write is attempted to an address with csr_addr[11:10]==2'b11; no state changes in that case.
REQ-020 On is_ecall: mepc<=pc, mcause<=11, MPIE<=MIE, MIE<=0; trap_taken=1; trap_npc = mtvec with bits[1:0] cleared (direct mode only).
REQ-021 On is_mret: MIE<=MPIE, MPIE<=1; trap_taken=1; trap_npc=mepc.
REQ-022 Priority SHALL be rst > is_ecall > is_mret > csr_en write; a lower-priority event in the same cycle SHALL be discarded.
REQ-023 mcycle SHALL be 64 bits and increment every cycle, with carry from the low into the high half and wrap from 2^64-1 to 0.
REQ-024 minstret SHALL be 64 bits and increment when inst_retire=1.
REQ-025 A CSR write to a counter half SHALL override that cycle's increment of the whole counter; the other half SHALL hold.
REQ-026 csr_rdata SHALL return the pre-write value in the same cycle; the written value SHALL be visible from the next cycle.

Reset
REQ-027 While rst=1: mstatus MIE=0 and MPIE=0; mtvec=MTVEC_RST; mepc, mcause, mscratch and both counters = 0; csr_illegal=0.
REQ-028 Reset asserted mid-trap or mid-write SHALL discard that event entirely.

Structure
REQ-029 CSR address constants, funct3 encodings and cause code 11 SHALL live in the shared defines package.
REQ-030 A 64-bit counter with split-half write and increment enable SHALL be one sub-module, csr_counter64, instantiated twice, gated by HAS_COUNTERS.

Verification
REQ-031 Reset, then CSRRW 0x305 with src1=0x8000_0100 -> csr_rdata=0; the next read of 0x305 returns 0x8000_0100.
REQ-032 mstatus.MIE=1, then is_ecall with pc=0x8000_0040 -> trap_npc=mtvec, mepc=0x8000_0040, mcause=11, mstatus=0x1880; is_mret -> trap_npc=0x8000_0040, mstatus=0x1888.
REQ-033 CSRRC 0x340 with mscratch=0xFF and zimm=0x0F (RCI) -> 0xF0; CSRRS with zimm=0 on 0xF11 -> no write and no csr_illegal.
REQ-034 Write 0xF12 or access 0x7C0 -> csr_illegal=1 for exactly one cycle, and state is unchanged.
REQ-035 XLEN=32: set mcycle=0xFFFF_FFFF, mcycleh=0 -> next cycle reads mcycle=0, mcycleh=1; a write to minstret while inst_retire=1 -> the written value wins.
REQ-036 Same cycle: is_ecall, is_mret and a csr_en write to mepc -> only the ecall effects occur.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, Zicsr funct3
// encodings, trap cause codes and the decoded operation type.
package csr_file_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam int unsigned CAUSE_ECALL_M = 11;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    // Addresses with [11:10] == 2'b11 are read-only by encoding.
    function automatic logic is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter whose 32-bit halves can be written independently;
// any half-write suppresses that cycle's increment of the whole counter.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic [1:0]  we,
    input  logic [63:0] wdata,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (|we) begin
            if (we[0]) count[31:0]  <= wdata[31:0];
            if (we[1]) count[63:32] <= wdata[63:32];
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode Zicsr register file with ecall/mret trap handling and optional
// mcycle/minstret counters.
module csr_file
    import csr_file_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter bit              HAS_COUNTERS = 1,
    parameter logic [XLEN-1:0] MTVEC_RST    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_en,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] src1,
    input  logic [4:0]      zimm,
    input  logic            is_ecall,
    input  logic            is_mret,
    input  logic            inst_retire,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] csr_rdata,
    output logic [XLEN-1:0] trap_npc,
    output logic            trap_taken,
    output logic            csr_illegal
);

    logic            mie, mpie;
    logic [XLEN-1:0] mtvec, mscratch, mcause;
    logic [XLEN-1:2] mepc;
    logic [63:0]     cycle, instret;

    csr_op_e         op;
    logic [XLEN-1:0] operand, wdata, mstatus_val;
    logic            impl, wr_req, illegal_now, trap, wr_fire;
    logic [1:0]      cyc_we, ins_we;
    logic [63:0]     cnt_wdata;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^pc[1:0];

    always_comb begin
        op = OP_NONE;
        case (funct3)
            F3_RW, F3_RWI: op = OP_RW;
            F3_RS, F3_RSI: op = OP_RS;
            F3_RC, F3_RCI: op = OP_RC;
            default:       op = OP_NONE;
        endcase
    end

    assign operand = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : src1;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mpie;
        mstatus_val[3]     = mie;
    end

    // Old-value read mux; impl also decides whether the address exists.
    always_comb begin
        csr_rdata = '0;
        impl      = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:  csr_rdata = mstatus_val;
            CSR_MTVEC:    csr_rdata = mtvec;
            CSR_MSCRATCH: csr_rdata = mscratch;
            CSR_MEPC:     csr_rdata = {mepc, 2'b00};
            CSR_MCAUSE:   csr_rdata = mcause;
            CSR_MCYCLE: begin
                impl = HAS_COUNTERS;
                if (impl) csr_rdata = cycle[XLEN-1:0];
            end
            CSR_MINSTRET: begin
                impl = HAS_COUNTERS;
                if (impl) csr_rdata = instret[XLEN-1:0];
            end
            CSR_MCYCLEH: begin
                impl = HAS_COUNTERS && (XLEN == 32);
                if (impl) csr_rdata = XLEN'(cycle[63:32]);
            end
            CSR_MINSTRETH: begin
                impl = HAS_COUNTERS && (XLEN == 32);
                if (impl) csr_rdata = XLEN'(instret[63:32]);
            end
            CSR_MVENDORID, CSR_MARCHID: csr_rdata = '0;
            default: impl = 1'b0;
        endcase
    end

    // Set/clear forms with a zero rs1 field are pure reads. An unknown funct3
    // is treated as a no-op rather than an illegal access.
    assign wr_req      = csr_en && ((op == OP_RW) || ((op != OP_NONE) && (zimm != 5'd0)));
    assign illegal_now = csr_en && (!impl || (wr_req && is_read_only(csr_addr)));
    assign trap        = is_ecall || is_mret;
    assign wr_fire     = wr_req && !illegal_now && !trap;

    always_comb begin
        wdata = operand;
        case (op)
            OP_RS:   wdata = csr_rdata | operand;
            OP_RC:   wdata = csr_rdata & ~operand;
            default: wdata = operand;
        endcase
    end

    assign trap_taken = !rst && trap;
    assign trap_npc   = is_ecall ? {mtvec[XLEN-1:2], 2'b00} : {mepc, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            mie         <= 1'b0;
            mpie        <= 1'b0;
            mtvec       <= MTVEC_RST;
            mscratch    <= '0;
            mepc        <= '0;
            mcause      <= '0;
            csr_illegal <= 1'b0;
        end else begin
            csr_illegal <= illegal_now && !trap;
            if (is_ecall) begin
                mepc   <= pc[XLEN-1:2];
                mcause <= XLEN'(CAUSE_ECALL_M);
                mpie   <= mie;
                mie    <= 1'b0;
            end else if (is_mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (wr_fire) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie  <= wdata[3];
                        mpie <= wdata[7];
                    end
                    CSR_MTVEC:    mtvec    <= wdata;
                    CSR_MSCRATCH: mscratch <= wdata;
                    CSR_MEPC:     mepc     <= wdata[XLEN-1:2];
                    CSR_MCAUSE:   mcause   <= wdata;
                    default: ;
                endcase
            end
        end
    end

    // On RV64 a low-address counter write covers both halves.
    always_comb begin
        cyc_we = 2'b00;
        ins_we = 2'b00;
        if (wr_fire) begin
            case (csr_addr)
                CSR_MCYCLE:    cyc_we = (XLEN == 32) ? 2'b01 : 2'b11;
                CSR_MINSTRET:  ins_we = (XLEN == 32) ? 2'b01 : 2'b11;
                CSR_MCYCLEH:   cyc_we = 2'b10;
                CSR_MINSTRETH: ins_we = 2'b10;
                default: ;
            endcase
        end
    end

    generate
        if (XLEN == 32) begin : g_wdata32
            assign cnt_wdata = {wdata, wdata};
        end else begin : g_wdata64
            assign cnt_wdata = wdata[63:0];
        end

        if (HAS_COUNTERS) begin : g_counters
            csr_counter64 u_mcycle (
                .clk   (clk),
                .rst   (rst),
                .inc   (1'b1),
                .we    (cyc_we),
                .wdata (cnt_wdata),
                .count (cycle)
            );
            csr_counter64 u_minstret (
                .clk   (clk),
                .rst   (rst),
                .inc   (inst_retire),
                .we    (ins_we),
                .wdata (cnt_wdata),
                .count (instret)
            );
        end else begin : g_no_counters
            assign cycle   = '0;
            assign instret = '0;
        end
    endgenerate

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file (XLEN=32): CSR ops, traps, priority, illegal
// accesses, counters with split-half writes, and reset discard.
module tb_csr_file;
    import csr_file_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            csr_en;
    logic [2:0]      funct3;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] src1;
    logic [4:0]      zimm;
    logic            is_ecall, is_mret, inst_retire;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] csr_rdata, trap_npc;
    logic            trap_taken, csr_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csr_file #(.XLEN(XLEN), .HAS_COUNTERS(1'b1), .MTVEC_RST('0)) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_en      (csr_en),
        .funct3      (funct3),
        .csr_addr    (csr_addr),
        .src1        (src1),
        .zimm        (zimm),
        .is_ecall    (is_ecall),
        .is_mret     (is_mret),
        .inst_retire (inst_retire),
        .pc          (pc),
        .csr_rdata   (csr_rdata),
        .trap_npc    (trap_npc),
        .trap_taken  (trap_taken),
        .csr_illegal (csr_illegal)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        csr_en      = 1'b0;
        funct3      = 3'b000;
        csr_addr    = 12'h000;
        src1        = '0;
        zimm        = 5'd0;
        is_ecall    = 1'b0;
        is_mret     = 1'b0;
        inst_retire = 1'b0;
        pc          = '0;
    endtask

    task automatic csr(input logic [2:0] f3, input logic [11:0] a, input logic [XLEN-1:0] s,
                       input logic [4:0] z);
        csr_en   = 1'b1;
        funct3   = f3;
        csr_addr = a;
        src1     = s;
        zimm     = z;
    endtask

    // Pure read: CSRRSI with a zero immediate.
    task automatic rd(input logic [11:0] a);
        csr(F3_RSI, a, '0, 5'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_illegal", csr_illegal, 0);
        rst = 1'b0;

        rd(CSR_MTVEC);                         #1 chk("mtvec_rst", csr_rdata, 32'h0);            cyc();
        csr(F3_RW, CSR_MTVEC, 32'h8000_0100, 5'd0); #1 chk("csrrw_old", csr_rdata, 32'h0);        cyc();
        csr(F3_RS, CSR_MTVEC, 32'hFFFF_FFFF, 5'd0); #1 chk("mtvec_new", csr_rdata, 32'h8000_0100); cyc();
        rd(CSR_MTVEC);                         #1 chk("rs_zero_nowrite", csr_rdata, 32'h8000_0100); cyc();

        rd(CSR_MSTATUS);                       #1 chk("mstatus_rst", csr_rdata, 32'h1800);       cyc();
        csr(F3_RSI, CSR_MSTATUS, '0, 5'd8);    #1 chk("mstatus_rsi_old", csr_rdata, 32'h1800);   cyc();
        rd(CSR_MSTATUS);                       #1 chk("mstatus_mie", csr_rdata, 32'h1808);       cyc();

        // ecall, mret and a mepc write all in one cycle: only the ecall lands.
        csr(F3_RW, CSR_MEPC, 32'h0000_1234, 5'd0);
        is_ecall = 1'b1;
        is_mret  = 1'b1;
        pc       = 32'h8000_0040;
        #1 chk("ecall_taken", trap_taken, 1);
        chk("ecall_npc", trap_npc, 32'h8000_0100);
        cyc();
        rd(CSR_MEPC);                          #1 chk("ecall_mepc", csr_rdata, 32'h8000_0040);   cyc();
        rd(CSR_MCAUSE);                        #1 chk("ecall_mcause", csr_rdata, 32'd11);        cyc();
        rd(CSR_MSTATUS);                       #1 chk("ecall_mstatus", csr_rdata, 32'h1880);     cyc();

        is_mret = 1'b1;
        #1 chk("mret_taken", trap_taken, 1);
        chk("mret_npc", trap_npc, 32'h8000_0040);
        cyc();
        rd(CSR_MSTATUS);                       #1 chk("mret_mstatus", csr_rdata, 32'h1888);      cyc();
        #1 chk("idle_no_trap", trap_taken, 0);

        csr(F3_RW, CSR_MSCRATCH, 32'hFF, 5'd0);                                                  cyc();
        csr(F3_RCI, CSR_MSCRATCH, '0, 5'h0F);  #1 chk("rci_old", csr_rdata, 32'hFF);             cyc();
        rd(CSR_MSCRATCH);                      #1 chk("rci_new", csr_rdata, 32'hF0);             cyc();

        csr(F3_RS, CSR_MVENDORID, 32'hDEAD, 5'd0); #1 chk("mvendorid", csr_rdata, 32'h0);        cyc();
        #1 chk("ro_read_legal", csr_illegal, 0);

        csr(F3_RW, CSR_MARCHID, 32'h5, 5'd0);                                                    cyc();
        #1 chk("ro_write_illegal", csr_illegal, 1);                                              cyc();
        #1 chk("ro_pulse_one", csr_illegal, 0);
        rd(CSR_MARCHID);                       #1 chk("marchid_held", csr_rdata, 32'h0);         cyc();

        csr(F3_RW, 12'h7C0, 32'h5, 5'd0);                                                        cyc();
        rd(CSR_MSCRATCH);
        #1 chk("unimpl_illegal", csr_illegal, 1);
        chk("unimpl_no_change", csr_rdata, 32'hF0);
        cyc();
        #1 chk("unimpl_pulse_one", csr_illegal, 0);

        // Low half set to all-ones, then high half cleared; the carry must propagate.
        csr(F3_RW, CSR_MCYCLE, 32'hFFFF_FFFF, 5'd0);                                             cyc();
        csr(F3_RW, CSR_MCYCLEH, 32'h0, 5'd0);                                                    cyc();
        rd(CSR_MCYCLE);                        #1 chk("mcycle_written", csr_rdata, 32'hFFFF_FFFF); cyc();
        rd(CSR_MCYCLE);                        #1 chk("mcycle_wrap", csr_rdata, 32'h0);          cyc();
        rd(CSR_MCYCLEH);                       #1 chk("mcycleh_carry", csr_rdata, 32'h1);        cyc();

        csr(F3_RW, CSR_MINSTRET, 32'h100, 5'd0);
        inst_retire = 1'b1;
        cyc();
        rd(CSR_MINSTRET);
        inst_retire = 1'b1;
        #1 chk("minstret_write_wins", csr_rdata, 32'h100);
        cyc();
        rd(CSR_MINSTRET);                      #1 chk("minstret_inc", csr_rdata, 32'h101);       cyc();
        rd(CSR_MINSTRETH);                     #1 chk("minstreth_hold", csr_rdata, 32'h0);       cyc();

        // Reset arriving together with an ecall and a write discards both.
        csr(F3_RW, CSR_MSCRATCH, 32'h55, 5'd0);
        is_ecall = 1'b1;
        pc       = 32'h0000_0044;
        rst      = 1'b1;
        #1 chk("rst_trap_masked", trap_taken, 0);
        cyc();
        rst = 1'b0;
        rd(CSR_MCYCLE);                        #1 chk("rst_mcycle", csr_rdata, 32'h0);
        chk("rst_illegal_after", csr_illegal, 0);
        cyc();
        rd(CSR_MSCRATCH);                      #1 chk("rst_mscratch", csr_rdata, 32'h0);         cyc();
        rd(CSR_MEPC);                          #1 chk("rst_mepc", csr_rdata, 32'h0);             cyc();
        rd(CSR_MCAUSE);                        #1 chk("rst_mcause", csr_rdata, 32'h0);           cyc();
        rd(CSR_MSTATUS);                       #1 chk("rst_mstatus", csr_rdata, 32'h1800);       cyc();
        rd(CSR_MTVEC);                         #1 chk("rst_mtvec", csr_rdata, 32'h0);            cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
